// File: rtl/rrat_retire_if.sv
// Retire-side bundle for the retirement RAT: ROB retire slots in, freed tags
// and the committed map out.
interface rrat_retire_if #(
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 7,
    parameter int AW       = $clog2(NUM_ARCH)
);
    logic [1:0]                rob_retire_num;
    logic [AW-1:0]             rob_retire_arch_0;
    logic [AW-1:0]             rob_retire_arch_1;
    logic [TAG_W-1:0]          rob_retire_pr_0;
    logic [TAG_W-1:0]          rob_retire_pr_1;
    logic [1:0]                fl_free_num;
    logic [TAG_W-1:0]          fl_free_tag_0;
    logic [TAG_W-1:0]          fl_free_tag_1;
    logic [NUM_ARCH*TAG_W-1:0] rrat_map_flat;

    modport master (
        output rob_retire_num, rob_retire_arch_0, rob_retire_arch_1,
               rob_retire_pr_0, rob_retire_pr_1,
        input  fl_free_num, fl_free_tag_0, fl_free_tag_1, rrat_map_flat
    );

    modport slave (
        input  rob_retire_num, rob_retire_arch_0, rob_retire_arch_1,
               rob_retire_pr_0, rob_retire_pr_1,
        output fl_free_num, fl_free_tag_0, fl_free_tag_1, rrat_map_flat
    );
endinterface

// File: rtl/rrat_retire.sv
// Retirement RAT: committed arch->phys map updated by up to two retires per
// cycle; displaced tags are returned to the free list one cycle later.

module rrat_map_entry #(
    parameter int               TAG_W   = 7,
    parameter logic [TAG_W-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [TAG_W-1:0] i_wdata,
    output logic [TAG_W-1:0] o_tag
);
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_tag <= RST_VAL;
        else if (i_we)
            r_tag <= i_wdata;
    end

    assign o_tag = r_tag;
endmodule

module rrat_retire #(
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 7
) (
    input  logic         clock,
    input  logic         reset,
    rrat_retire_if.slave rif
);
    localparam int AW = $clog2(NUM_ARCH);

    logic [NUM_ARCH-1:0][TAG_W-1:0] w_map;
    logic [NUM_ARCH-1:0][TAG_W-1:0] w_wdata;
    logic [NUM_ARCH-1:0]            w_we;
    logic                           w_ret1;
    logic                           w_ret2;
    logic                           w_same;
    logic [TAG_W-1:0]               w_old0;
    logic [TAG_W-1:0]               w_old1;

    logic [1:0]       r_free_num;
    logic [TAG_W-1:0] r_free_tag_0;
    logic [TAG_W-1:0] r_free_tag_1;

    assign w_ret1 = (rif.rob_retire_num == 2'd1);
    assign w_ret2 = (rif.rob_retire_num == 2'd2);
    assign w_same = w_ret2 && (rif.rob_retire_arch_0 == rif.rob_retire_arch_1);

    // Slot 1 data wins on its own entry, so an arch collision commits pr_1.
    for (genvar a = 0; a < NUM_ARCH; a++) begin : g_ent
        logic w_hit0;
        logic w_hit1;
        assign w_hit0     = (w_ret1 || w_ret2) && (rif.rob_retire_arch_0 == AW'(a));
        assign w_hit1     = w_ret2 && (rif.rob_retire_arch_1 == AW'(a));
        assign w_we[a]    = w_hit0 || w_hit1;
        assign w_wdata[a] = w_hit1 ? rif.rob_retire_pr_1 : rif.rob_retire_pr_0;

        rrat_map_entry #(
            .TAG_W   (TAG_W),
            .RST_VAL (TAG_W'(a))
        ) u_ent (
            .clock   (clock),
            .reset   (reset),
            .i_we    (w_we[a]),
            .i_wdata (w_wdata[a]),
            .o_tag   (w_map[a])
        );
    end

    // Old mappings come from the pre-edge table.
    assign w_old0 = w_map[rif.rob_retire_arch_0];
    assign w_old1 = w_map[rif.rob_retire_arch_1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_free_num   <= 2'd0;
            r_free_tag_0 <= '0;
            r_free_tag_1 <= '0;
        end else if (w_ret1) begin
            r_free_num   <= 2'd1;
            r_free_tag_0 <= w_old0;
            r_free_tag_1 <= '0;
        end else if (w_ret2) begin
            // Same-arch pair: slot 0's fresh tag is dead on arrival.
            r_free_num   <= 2'd2;
            r_free_tag_0 <= w_old0;
            r_free_tag_1 <= w_same ? rif.rob_retire_pr_0 : w_old1;
        end else begin
            r_free_num   <= 2'd0;
            r_free_tag_0 <= '0;
            r_free_tag_1 <= '0;
        end
    end

    assign rif.fl_free_num   = r_free_num;
    assign rif.fl_free_tag_0 = r_free_tag_0;
    assign rif.fl_free_tag_1 = r_free_tag_1;
    assign rif.rrat_map_flat = w_map;
endmodule

// File: doc/rrat_retire.md
RRAT_RETIRE -- requirements
Module: rrat_retire

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears state immediately, independent of clock.
REQ-003 SHALL have port: rob_retire_num  input  2  number of instructions retiring this cycle (0, 1, 2); value 3 illegal.
REQ-004 SHALL have port: rob_retire_arch_0  input  5  architectural destination of retire slot 0 (older).
REQ-005 SHALL have port: rob_retire_arch_1  input  5  architectural destination of retire slot 1 (younger).
REQ-006 SHALL have port: rob_retire_pr_0  input  7  physical tag committed by slot 0.
REQ-007 SHALL have port: rob_retire_pr_1  input  7  physical tag committed by slot 1.
REQ-008 SHALL have port: fl_free_num  output  2  count of tags returned to the free list (0, 1, 2).
REQ-009 SHALL have port: fl_free_tag_0  output  7  first freed physical tag.
REQ-010 SHALL have port: fl_free_tag_1  output  7  second freed physical tag.
REQ-011 SHALL have port: rrat_map_flat  output  224  committed map; bits [7a+6:7a] hold the tag for arch register a.

Function
REQ-012 SHALL hold a 32-entry x 7-bit committed map table, one entry per architectural register.
REQ-013 SHALL drive rrat_map_flat directly from the map table register contents (no combinational bypass of same-cycle retires).
REQ-014 SHALL, on a clock edge with rob_retire_num=1, write map[arch_0] <= pr_0 and register free_num=1, free_tag_0 = pre-edge map[arch_0], free_tag_1 = 0.
REQ-015 SHALL, on a clock edge with rob_retire_num=2 and arch_0 != arch_1, write map[arch_0] <= pr_0, map[arch_1] <= pr_1, and register free_num=2, free_tag_0 = old map[arch_0], free_tag_1 = old map[arch_1].
REQ-016 SHALL, with rob_retire_num=2 and arch_0 == arch_1, write map[arch_0] <= pr_1 only, and register free_num=2, free_tag_0 = old map[arch_0], free_tag_1 = pr_0 (slot 1 supersedes slot 0).
REQ-017 SHALL, with rob_retire_num=0 or 3, leave the map unchanged and register free_num=0, free_tag_0=0, free_tag_1=0.
REQ-018 SHALL register all three fl_* outputs: freed tags appear exactly one cycle after the retire edge and are valid for exactly one cycle.
REQ-019 SHALL drive unused fl_free_tag slots as 0 (tag 0 is never interpreted when free_num excludes it).
REQ-020 SHALL pass 7-bit tag values through unmodified; no range check against 95 and no wrap arithmetic in this block.
REQ-021 SHALL treat arch register 31 like any other entry (no special zero-register handling).
REQ-022 SHALL accept back-to-back retires every cycle with no stall; the free list has no backpressure.
REQ-023 SHALL compute old-map reads from the pre-edge table, so a retire in cycle N+1 to the same arch reg as cycle N frees the tag committed in cycle N.

Reset
REQ-024 SHALL, while reset is high, force map[a] = a for a = 0..31 (matches free list initially holding tags 32..95).
REQ-025 SHALL, while reset is high, force fl_free_num=0, fl_free_tag_0=0, fl_free_tag_1=0.
REQ-026 SHALL discard any retire presented in the cycle reset asserts; a pending registered free output is cleared, not delivered.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL be verified by: reset then idle -> rrat_map_flat shows map[a]=a for all a, fl_free_num=0.
REQ-029 SHALL be verified by: after reset, num=1, arch_0=5, pr_0=40 -> next cycle fl_free_num=1, tag_0=5; map[5]=40.
REQ-030 SHALL be verified by: num=2, arch_0=3/pr_0=33, arch_1=7/pr_1=50 -> fl_free_num=2, tags 3 and 7; map[3]=33, map[7]=50.
REQ-031 SHALL be verified by: num=2, arch_0=arch_1=9, pr_0=60, pr_1=61 -> fl_free_num=2, tag_0=9, tag_1=60; map[9]=61.
REQ-032 SHALL be verified by: cycle N num=1 arch 4/pr 70, cycle N+1 num=1 arch 4/pr 71 -> frees 4 then 70; map[4]=71.
REQ-033 SHALL be verified by: num=2 retire, reset asserted asynchronously mid-cycle before output edge -> fl_free_num=0 immediately, map back to identity; num=3 input -> no change, free_num=0.
